// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

  localparam int          ADDR_W_DEF = 10;
  localparam int          DEPTH_DEF  = 1 << ADDR_W_DEF;
  localparam logic [31:0] FAULT_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Arbitrates the single instruction-memory port between the boot-load stream and CPU fetch.
// Fetch latency is one cycle at one per cycle; loader and fetch are gated by ld_ready/fetch_ready per state.
module imem_boot_ctrl #(
  parameter int ADDR_W = imem_ctrl_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);
  import imem_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              load_err_q, load_err_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [31:0]       fetch_instr_q, fetch_instr_d;
  logic              fetch_fault_q, fetch_fault_d;

  logic              full;
  logic              fetch_bad;

  // The write pointer doubles as the load count; its top bit means all DEPTH words are in.
  assign full      = wr_ptr_q[ADDR_W];
  assign fetch_bad = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_W+2]);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    load_err_d    = load_err_q;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_fault_d = fetch_fault_q;
    ld_ready      = 1'b0;
    fetch_ready   = 1'b0;
    cpu_hold      = 1'b1;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;

    case (state_q)
      S_IDLE: begin
        if (boot_start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          load_err_d = 1'b0;
        end
      end

      S_LOAD: begin
        ld_ready  = 1'b1;
        mem_addr  = wr_ptr_q[ADDR_W-1:0];
        mem_wdata = ld_data;
        mem_we    = ld_valid & ~full;
        if (ld_valid) begin
          if (!full) begin
            wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
            if (ld_last) state_d = S_RUN;
          end else begin
            // Image larger than the memory: drop the word and park in ERR.
            load_err_d = 1'b1;
            state_d    = S_ERR;
          end
        end
      end

      S_RUN: begin
        fetch_ready = 1'b1;
        cpu_hold    = 1'b0;
        mem_addr    = fetch_addr[ADDR_W+1:2];
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_instr_d = fetch_bad ? FAULT_WORD : mem_rdata;
          fetch_fault_d = fetch_bad;
        end
        if (boot_start) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        // The response registered on the last RUN cycle is presented here.
        state_d    = S_LOAD;
        wr_ptr_d   = '0;
        load_err_d = 1'b0;
      end

      S_ERR: begin
        if (boot_start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          load_err_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      load_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_err_q    <= load_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign load_count  = wr_ptr_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: memory array, behavioural reference model with a per-cycle
// compare, and directed scenarios with literal expectations.
module tb_imem_boot_ctrl;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DRAIN = 3, M_ERR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              boot_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              cpu_hold;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [32:0] resp_q  [$];

  // Reference model state
  int          m_mode  = M_IDLE;
  int          m_count = 0;
  bit          m_err   = 1'b0;
  bit          m_rv    = 1'b0;
  logic [31:0] m_ri    = '0;
  bit          m_rf    = 1'b0;

  logic [31:0] img [12] = '{32'h00500c63, 32'h00002083, 32'h01402103, 32'h00a00193,
                            32'h00308233, 32'h004202b3, 32'h00512023, 32'h00410113,
                            32'hfff18193, 32'h00019463, 32'h00100513, 32'hff5ff36f};

  imem_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .load_count(load_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model: what the block must do, stated per cycle in terms of the image and requests.
  always @(posedge clk) begin
    int  nm, nc;
    bit  ne, nrv, bad;
    logic [31:0] nri;
    bit  nrf;
    nm = m_mode; nc = m_count; ne = m_err; nrv = 1'b0; nri = m_ri; nrf = m_rf;
    if (rst) begin
      nm = M_IDLE; nc = 0; ne = 1'b0; nri = '0; nrf = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (boot_start) begin nm = M_LOAD; nc = 0; ne = 1'b0; end
        M_LOAD: if (ld_valid) begin
          if (m_count < DEPTH) begin
            ref_mem[m_count] <= ld_data;
            nc = m_count + 1;
            if (ld_last) nm = M_RUN;
          end else begin
            ne = 1'b1; nm = M_ERR;
          end
        end
        M_RUN: begin
          if (fetch_req) begin
            bad = (fetch_addr % 4 != 0) || (fetch_addr >= 32'(4 * DEPTH));
            nrv = 1'b1;
            nrf = bad;
            nri = bad ? 32'h0 : ref_mem[(fetch_addr / 4) % DEPTH];
          end
          if (boot_start) nm = M_DRAIN;
        end
        M_DRAIN: begin nm = M_LOAD; nc = 0; ne = 1'b0; end
        default: if (boot_start) begin nm = M_LOAD; nc = 0; ne = 1'b0; end
      endcase
    end
    m_mode <= nm; m_count <= nc; m_err <= ne; m_rv <= nrv; m_ri <= nri; m_rf <= nrf;
  end

  // Per-cycle compare of every output against the model; also logs responses.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] e_addr;
    bit e_we;
    bit ok;
    if (fetch_valid) resp_q.push_back({fetch_fault, fetch_instr});
    if (chk_en) begin
      e_addr = '0;
      e_we   = 1'b0;
      if (m_mode == M_LOAD) begin
        e_addr = ADDR_W'(m_count % DEPTH);
        e_we   = ld_valid && (m_count < DEPTH);
      end else if (m_mode == M_RUN) begin
        e_addr = ADDR_W'((fetch_addr / 4) % DEPTH);
      end
      ok = (cpu_hold === (m_mode != M_RUN)) && (ld_ready === (m_mode == M_LOAD)) &&
           (fetch_ready === (m_mode == M_RUN)) && (fetch_valid === m_rv) &&
           (fetch_instr === m_ri) && (fetch_fault === m_rf) &&
           (load_count === (ADDR_W+1)'(m_count)) && (load_err === m_err) &&
           (mem_addr === e_addr) && (mem_we === e_we) &&
           (!e_we || mem_wdata === ld_data);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t act hold=%b ldr=%b frdy=%b fv=%b fi=%h ff=%b cnt=%0d err=%b ma=%0d we=%b req hold=%b ldr=%b frdy=%b fv=%b fi=%h ff=%b cnt=%0d err=%b ma=%0d we=%b",
                 $time, cpu_hold, ld_ready, fetch_ready, fetch_valid, fetch_instr, fetch_fault,
                 load_count, load_err, mem_addr, mem_we,
                 m_mode != M_RUN, m_mode == M_LOAD, m_mode == M_RUN, m_rv, m_ri, m_rf,
                 m_count, m_err, e_addr, e_we);
      end
    end
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic boot();
    boot_start = 1'b1; tick(); boot_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a; tick(); fetch_req = 1'b0;
  endtask

  task automatic pop_resp(input string name, input logic [32:0] exp);
    if (resp_q.size() == 0) chk({name, "_missing"}, 33'h1, 33'h0);
    else chk(name, resp_q.pop_front(), exp);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; boot_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_cpu_hold", 33'(cpu_hold), 33'h1);
    chk("rst_load_count", 33'(load_count), 33'h0);
    chk("rst_fetch_valid", 33'(fetch_valid), 33'h0);

    // 12-word image
    boot();
    for (int i = 0; i < 12; i++) send(img[i], i == 11);
    settle();
    chk("load_cpu_hold", 33'(cpu_hold), 33'h0);
    chk("load_count12", 33'(load_count), 33'd12);
    chk("mem11", 33'(mem[11]), 33'h0ff5ff36f);

    resp_q.delete();
    fetch_req = 1'b1; fetch_addr = 32'h0;  tick();
    fetch_addr = 32'h4;  tick();
    fetch_addr = 32'h2C; tick();
    fetch_req = 1'b0;
    settle();
    chk("b2b_count", 33'(resp_q.size()), 33'd3);
    pop_resp("fetch_0x0", 33'h000500c63);
    pop_resp("fetch_0x4", 33'h000002083);
    pop_resp("fetch_0x2c", 33'h0ff5ff36f);

    fetch(32'h2);
    fetch(32'h1000);
    settle();
    pop_resp("fault_0x2", 33'h100000000);
    pop_resp("fault_0x1000", 33'h100000000);
    chk("mem0_kept", 33'(mem[0]), 33'h000500c63);

    // Reload request coincident with an accepted fetch
    resp_q.delete();
    fetch_req = 1'b1; fetch_addr = 32'h8; boot_start = 1'b1; tick();
    fetch_req = 1'b0; boot_start = 1'b0;
    settle();
    pop_resp("drain_resp", 33'h001402103);
    chk("drain_fetch_ready", 33'(fetch_ready), 33'h0);
    tick(); settle();
    chk("reload_ld_ready", 33'(ld_ready), 33'h1);
    chk("reload_wr_ptr", 33'(mem_addr), 33'h0);

    // Overflow: 1025 words without ld_last
    for (int i = 0; i < DEPTH + 1; i++) send(32'hA000_0000 + 32'(i), 1'b0);
    settle();
    chk("ovf_load_err", 33'(load_err), 33'h1);
    chk("ovf_ld_ready", 33'(ld_ready), 33'h0);
    chk("ovf_count", 33'(load_count), 33'd1024);
    chk("ovf_mem1023", 33'(mem[1023]), 33'h0A00003FF);
    chk("ovf_mem0", 33'(mem[0]), 33'h0A0000000);
    boot();
    settle();
    chk("err_cleared", 33'(load_err), 33'h0);

    // Reset in the middle of a load
    for (int i = 0; i < 5; i++) send(32'hB000_0000 + 32'(i), 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    settle();
    chk("midrst_hold", 33'(cpu_hold), 33'h1);
    chk("midrst_count", 33'(load_count), 33'h0);
    chk("midrst_ld_ready", 33'(ld_ready), 33'h0);
    chk("midrst_mem4", 33'(mem[4]), 33'h0B0000004);
    chk("midrst_mem5", 33'(mem[5]), 33'h0A0000005);

    // Single-word image
    boot();
    send(32'h1234_5678, 1'b1);
    settle();
    chk("one_word_run", 33'(cpu_hold), 33'h0);
    chk("one_word_count", 33'(load_count), 33'd1);

    // Full DEPTH image with ld_last on the final word, reloaded from RUN
    boot();
    tick();
    for (int i = 0; i < DEPTH; i++) send(32'hC000_0000 + 32'(i), i == DEPTH - 1);
    settle();
    chk("full_run", 33'(cpu_hold), 33'h0);
    chk("full_err", 33'(load_err), 33'h0);
    chk("full_count", 33'(load_count), 33'd1024);
    resp_q.delete();
    fetch(32'hFFC);
    settle();
    pop_resp("fetch_0xffc", 33'h0C00003FF);

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
